// File: rtl/alu_result_select_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_select_pipe_if
// Description : Upstream/downstream handshake bundle for alu_result_select_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_select_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 9,
    parameter int SEL_W   = 4
);
    logic [NUM_OPS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_err;
    logic                     out_valid;
    logic                     out_ready;
`ifdef ALU_SEL_FLAGS_EN
    logic                     out_zero;
    logic                     out_neg;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid, out_zero, out_neg
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid, out_zero, out_neg
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_result_select_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_select_pipe
// Description : Registered ALU result mux behind a 2-entry skid buffer.
//               Optional zero/neg flags enabled by macro ALU_SEL_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_select_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 9,
    parameter int SEL_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_result_select_pipe_if.slave   alu_if
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
`ifdef ALU_SEL_FLAGS_EN
        logic             zero;
        logic             neg;
`endif
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic beat_t f_reset_beat();
        beat_t b;
        b = '0;
`ifdef ALU_SEL_FLAGS_EN
        b.zero = 1'b1;
`endif
        return b;
    endfunction

    localparam beat_t c_beat_rst = f_reset_beat();

    state_t state_q, state_d;
    beat_t  m_q, m_d;
    beat_t  s_q, s_d;
    beat_t  w_beat;
    logic   w_accept;
    logic   w_emit;

    // Out-of-range selects fall through the loop untouched: data 0, err 1.
    always_comb begin
        w_beat     = '0;
        w_beat.sel = alu_if.in_sel;
        w_beat.err = 1'b1;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (int'(alu_if.in_sel) == i) begin
                w_beat.data = alu_if.in_data[i*WIDTH +: WIDTH];
                w_beat.err  = 1'b0;
            end
        end
`ifdef ALU_SEL_FLAGS_EN
        w_beat.zero = (w_beat.data == '0);
        w_beat.neg  = w_beat.data[WIDTH-1];
`endif
    end

    assign w_accept = alu_if.in_valid  & (state_q != ST_FULL);
    assign w_emit   = alu_if.out_ready & (state_q != ST_EMPTY);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    m_d     = w_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_emit) begin
                    m_d = w_beat;
                end else if (w_accept) begin
                    s_d     = w_beat;
                    state_d = ST_FULL;
                end else if (w_emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_emit) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= c_beat_rst;
            s_q     <= c_beat_rst;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    // Ready depends only on registered state, never on out_ready.
    assign alu_if.in_ready  = (state_q != ST_FULL);
    assign alu_if.out_valid = (state_q != ST_EMPTY);
    assign alu_if.out_data  = m_q.data;
    assign alu_if.out_sel   = m_q.sel;
    assign alu_if.out_err   = m_q.err;
`ifdef ALU_SEL_FLAGS_EN
    assign alu_if.out_zero  = m_q.zero;
    assign alu_if.out_neg   = m_q.neg;
`endif

endmodule
`default_nettype wire
